// File: rtl/dpb_pkg.sv
// Shared types and helpers for the DPB slot reader: FSM states, header field
// positions (counted down from the word MSB) and the payload length rule.
package dpb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEAD_WAIT,
    SEND,
    RELEASE
  } dpb_state_t;

  // Each offset is the distance of the field's lowest bit below DATA_W.
  localparam int HDR_LAST_OFS = 1;
  localparam int HDR_RANK_OFS = 16;
  localparam int HDR_WCNT_OFS = 24;
  localparam int HDR_TAIL_OFS = 32;
  localparam int HDR_RANK_W   = 15;

  // On the last packet the final word holds only the tail bytes, so it is
  // not counted as a full word; a zero word count must not underflow.
  function automatic logic [15:0] calc_len(input logic        last,
                                           input logic [7:0]  wcnt,
                                           input logic [7:0]  tail,
                                           input logic [15:0] bytes_per_word);
    logic [15:0] words;
    if (!last)
      words = {8'd0, wcnt};
    else if (wcnt == 8'd0)
      words = 16'd0;
    else
      words = {8'd0, wcnt} - 16'd1;
    return 16'(words * bytes_per_word) + {8'd0, tail};
  endfunction

endpackage

// File: rtl/dpb_slot_reader_hdr_decode.sv
// Combinational decode of a slot header word into packet metadata.
module dpb_hdr_decode
  import dpb_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic [DATA_W-1:0] hdr,
  output logic              last,
  output logic [14:0]       rank,
  output logic [15:0]       len,
  output logic [31:0]       sign
);

  localparam int RANK_LSB = DATA_W - HDR_RANK_OFS;
  localparam int WCNT_LSB = DATA_W - HDR_WCNT_OFS;
  localparam int TAIL_LSB = DATA_W - HDR_TAIL_OFS;
  localparam logic [15:0] BYTES = 16'(DATA_W / 8);

  logic [7:0] wcnt;
  logic [7:0] tail;
  logic       unused_fill;

  assign last = hdr[DATA_W-HDR_LAST_OFS];
  assign rank = hdr[RANK_LSB +: HDR_RANK_W];
  assign wcnt = hdr[WCNT_LSB +: 8];
  assign tail = hdr[TAIL_LSB +: 8];
  assign sign = hdr[31:0];
  assign len  = calc_len(last, wcnt, tail, BYTES);

  // Bits between the tail field and the sign are reserved.
  if (DATA_W > 64) begin : g_fill
    assign unused_fill = ^hdr[TAIL_LSB-1:32];
  end else begin : g_nofill
    assign unused_fill = 1'b0;
  end

endmodule

// File: rtl/dpb_slot_reader.sv
// Read-side master of the packet staging BRAM ring: validates slot headers,
// presents packet metadata to the UDP transmitter and releases slots.
module dpb_slot_reader
  import dpb_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int SLOT_NUM_W  = 4,
  parameter int SLOT_WORD_W = 7,
  parameter int RD_LAT      = 2,
  parameter int IPV4_STEP   = 2,
  parameter int RESYNC      = 1,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic                          i_clk50m,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  logic [SLOT_NUM_W-1:0]         i_wr_slot_p,
  output logic [SLOT_NUM_W+SLOT_WORD_W-1:0] o_bram_addr,
  output logic                          o_bram_ce,
  input  logic [DATA_W-1:0]             i_bram_rd_data,
  output logic                          o_tx_en,
  output logic [DATA_W-1:0]             o_tx_data,
  output logic                          o_tx_last_frame,
  output logic [14:0]                   o_tx_frame_rank,
  output logic [15:0]                   o_tx_len,
  output logic [15:0]                   o_tx_ipv4_id,
  input  logic [SLOT_WORD_W-1:0]        i_tx_req_word,
  input  logic                          i_tx_started,
  input  logic                          i_tx_busy,
  output logic [SLOT_NUM_W-1:0]         o_rd_slot_p,
  output logic [7:0]                    o_seq_err_cnt,
  output logic                          o_timeout_pulse
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0]      LAT_LAST = 3'(RD_LAT - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  dpb_state_t            state;
  logic [SLOT_NUM_W-1:0] head;
  logic [31:0]           exp_sign;
  logic [2:0]            lat_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  started;
  logic                  hdr_sel;

  logic        hdr_last;
  logic [14:0] hdr_rank;
  logic [15:0] hdr_len;
  logic [31:0] hdr_sign;

  dpb_hdr_decode #(.DATA_W(DATA_W)) u_hdr_decode (
    .hdr  (i_bram_rd_data),
    .last (hdr_last),
    .rank (hdr_rank),
    .len  (hdr_len),
    .sign (hdr_sign)
  );

  // Word 0 of the head slot is kept addressed outside SEND, so the header is
  // already in flight through the BRAM pipeline when HEAD_WAIT starts.
  assign hdr_sel     = (state != SEND);
  assign o_bram_addr = {head, hdr_sel ? {SLOT_WORD_W{1'b0}} : i_tx_req_word};
  assign o_tx_data   = i_bram_rd_data;
  assign o_rd_slot_p = head;

  always_ff @(posedge i_clk50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      head            <= '0;
      exp_sign        <= '0;
      lat_cnt         <= '0;
      to_cnt          <= '0;
      started         <= 1'b0;
      o_bram_ce       <= 1'b0;
      o_tx_en         <= 1'b0;
      o_tx_last_frame <= 1'b0;
      o_tx_frame_rank <= '0;
      o_tx_len        <= '0;
      o_tx_ipv4_id    <= '0;
      o_seq_err_cnt   <= '0;
      o_timeout_pulse <= 1'b0;
    end else begin
      o_bram_ce       <= 1'b1;
      o_timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (i_enable && (head != i_wr_slot_p) && !i_tx_busy) begin
            lat_cnt <= '0;
            state   <= HEAD_WAIT;
          end
        end
        HEAD_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            if ((hdr_sign != exp_sign) && (o_seq_err_cnt != 8'hFF))
              o_seq_err_cnt <= o_seq_err_cnt + 8'd1;
            if ((hdr_sign == exp_sign) || (RESYNC != 0)) begin
              o_tx_last_frame <= hdr_last;
              o_tx_frame_rank <= hdr_rank;
              o_tx_len        <= hdr_len;
              exp_sign        <= hdr_sign + 32'd1;
              o_tx_ipv4_id    <= o_tx_ipv4_id + 16'(IPV4_STEP);
              o_tx_en         <= 1'b1;
              to_cnt          <= '0;
              started         <= 1'b0;
              state           <= SEND;
            end else begin
              head  <= head + SLOT_NUM_W'(1);
              state <= IDLE;
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        SEND: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (i_tx_started) begin
            o_tx_en <= 1'b0;
            started <= 1'b1;
          end
          if (to_cnt == TO_LAST) begin
            o_tx_en         <= 1'b0;
            o_timeout_pulse <= 1'b1;
            state           <= RELEASE;
          end else if ((started || i_tx_started) && !i_tx_busy) begin
            state <= RELEASE;
          end
        end
        RELEASE: begin
          head    <= head + SLOT_NUM_W'(1);
          started <= 1'b0;
          to_cnt  <= '0;
          lat_cnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpb_slot_reader.sv
// Self-checking bench for dpb_slot_reader: directed table, randomized ring
// traffic against a queue-based model, timeout, reset and drop-mode cases.
module tb_dpb_slot_reader;

  localparam int DW  = 128;
  localparam int SNW = 4;
  localparam int SWW = 7;
  localparam int LAT = 2;
  localparam int B   = DW / 8;

  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic rst_n;

  logic [DW-1:0] mem [0:(1<<(SNW+SWW))-1];

  logic en_a, tx_en_a, last_a, started_a, busy_a, ce_a, to_a;
  logic [SNW-1:0] wr_a, rd_slot_a;
  logic [SNW+SWW-1:0] addr_a;
  logic [DW-1:0] pipe_a, rd_a, tx_data_a;
  logic [14:0] rank_a;
  logic [15:0] len_a, id_a;
  logic [SWW-1:0] req_a;
  logic [7:0] err_a;

  logic en_b, tx_en_b, last_b, started_b, busy_b, ce_b, to_b;
  logic [SNW-1:0] wr_b, rd_slot_b;
  logic [SNW+SWW-1:0] addr_b;
  logic [DW-1:0] pipe_b, rd_b, tx_data_b;
  logic [14:0] rank_b;
  logic [15:0] len_b, id_b;
  logic [SWW-1:0] req_b;
  logic [7:0] err_b;

  dpb_slot_reader #(.RESYNC(1), .TIMEOUT_CYC(20)) u_dut_a (
    .i_clk50m(clk), .i_rst_n(rst_n), .i_enable(en_a), .i_wr_slot_p(wr_a),
    .o_bram_addr(addr_a), .o_bram_ce(ce_a), .i_bram_rd_data(rd_a),
    .o_tx_en(tx_en_a), .o_tx_data(tx_data_a), .o_tx_last_frame(last_a),
    .o_tx_frame_rank(rank_a), .o_tx_len(len_a), .o_tx_ipv4_id(id_a),
    .i_tx_req_word(req_a), .i_tx_started(started_a), .i_tx_busy(busy_a),
    .o_rd_slot_p(rd_slot_a), .o_seq_err_cnt(err_a), .o_timeout_pulse(to_a));

  dpb_slot_reader #(.RESYNC(0)) u_dut_b (
    .i_clk50m(clk), .i_rst_n(rst_n), .i_enable(en_b), .i_wr_slot_p(wr_b),
    .o_bram_addr(addr_b), .o_bram_ce(ce_b), .i_bram_rd_data(rd_b),
    .o_tx_en(tx_en_b), .o_tx_data(tx_data_b), .o_tx_last_frame(last_b),
    .o_tx_frame_rank(rank_b), .o_tx_len(len_b), .o_tx_ipv4_id(id_b),
    .i_tx_req_word(req_b), .i_tx_started(started_b), .i_tx_busy(busy_b),
    .o_rd_slot_p(rd_slot_b), .o_seq_err_cnt(err_b), .o_timeout_pulse(to_b));

  // Two-cycle read latency BRAM, one read port per reader.
  always @(posedge clk) begin
    pipe_a <= mem[addr_a];
    rd_a   <= pipe_a;
    pipe_b <= mem[addr_b];
    rd_b   <= pipe_b;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: slots still to be read, expected sign, id, error count, head.
  logic [DW-1:0] hdr_q[$];
  logic [31:0]   m_sign;
  logic [15:0]   m_id;
  int            m_err;
  logic [SNW-1:0] m_head;

  function automatic logic [DW-1:0] make_hdr(input logic last, input logic [14:0] rank,
                                             input logic [7:0] w, input logic [7:0] t,
                                             input logic [31:0] s);
    return {last, rank, w, t, $urandom, $urandom, s};
  endfunction

  function automatic logic [15:0] exp_len(input logic [DW-1:0] h);
    int n;
    n = int'(h[111:104]);
    if (h[127]) n = (n == 0) ? 0 : n - 1;
    return 16'(n * B + int'(h[103:96]));
  endfunction

  task automatic write_slot_a(input logic [DW-1:0] h);
    mem[{wr_a, 7'd0}] = h;
    hdr_q.push_back(h);
    wr_a = wr_a + 4'd1;
  endtask

  task automatic wait_tx_en_a(input string name);
    int k = 0;
    while (tx_en_a !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check(name, 128'(tx_en_a), 128'(1));
  endtask

  task automatic serve_a();
    logic [DW-1:0] h;
    logic [SWW-1:0] wd;
    logic [SNW-1:0] slot, nslot;
    int k, v;
    h = hdr_q.pop_front();
    if (h[31:0] != m_sign) m_err = (m_err < 255) ? m_err + 1 : 255;
    m_sign = h[31:0] + 32'd1;
    m_id   = m_id + 16'd2;
    slot   = m_head;
    nslot  = slot + 4'd1;
    wait_tx_en_a("tx_en_rise");
    check("tx_len", 128'(len_a), 128'(exp_len(h)));
    check("tx_ipv4_id", 128'(id_a), 128'(m_id));
    check("tx_last", 128'(last_a), 128'(h[127]));
    check("tx_rank", 128'(rank_a), 128'(h[126:112]));
    check("seq_err_cnt", 128'(err_a), 128'(m_err));
    check("rd_slot_in_send", 128'(rd_slot_a), 128'(slot));
    wd = SWW'($urandom);
    req_a = wd;
    repeat (LAT) @(negedge clk);
    check("tx_data", tx_data_a, mem[{slot, wd}]);
    v = $urandom_range(0, 2);
    started_a = 1'b1;
    busy_a = (v != 0);
    @(negedge clk);
    started_a = 1'b0;
    check("tx_en_after_start", 128'(tx_en_a), 128'(0));
    repeat (v * 2) @(negedge clk);
    busy_a = 1'b0;
    k = 0;
    while (rd_slot_a !== nslot && k < 50) begin @(negedge clk); k++; end
    check("rd_slot_release", 128'(rd_slot_a), 128'(nslot));
    m_head = nslot;
  endtask

  typedef struct {
    logic        last;
    logic [14:0] rank;
    logic [7:0]  w;
    logic [7:0]  t;
    logic [31:0] sign;
    logic [15:0] len;
    logic [15:0] id;
    logic [7:0]  err;
  } vec_t;
  vec_t tbl [7];

  initial begin
    logic seen;
    logic [31:0] ws, s;
    logic [SNW-1:0] slot;
    logic [DW-1:0] hb;
    int k, n;

    tbl[0] = '{1'b0, 15'h0011, 8'd10, 8'd5, 32'd0,  16'd165, 16'd2,  8'd0};
    tbl[1] = '{1'b0, 15'h0012, 8'd10, 8'd5, 32'd1,  16'd165, 16'd4,  8'd0};
    tbl[2] = '{1'b0, 15'h0013, 8'd10, 8'd5, 32'd2,  16'd165, 16'd6,  8'd0};
    tbl[3] = '{1'b1, 15'h5A5A, 8'd4,  8'd7, 32'd3,  16'd55,  16'd8,  8'd0};
    tbl[4] = '{1'b0, 15'h7FFF, 8'd0,  8'd9, 32'd9,  16'd9,   16'd10, 8'd1};
    tbl[5] = '{1'b0, 15'h0001, 8'd1,  8'd0, 32'd10, 16'd16,  16'd12, 8'd1};
    tbl[6] = '{1'b1, 15'h0002, 8'd0,  8'd3, 32'd11, 16'd3,   16'd14, 8'd1};

    for (int i = 0; i < (1 << (SNW + SWW)); i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    rst_n = 1'b0;
    en_a = 0; wr_a = 0; req_a = 0; started_a = 0; busy_a = 0;
    en_b = 0; wr_b = 0; req_b = 0; started_b = 0; busy_b = 0;
    m_sign = 0; m_id = 0; m_err = 0; m_head = 0;

    repeat (3) @(negedge clk);
    check("rst_tx_en", 128'(tx_en_a), 128'(0));
    check("rst_ipv4_id", 128'(id_a), 128'(0));
    check("rst_len", 128'(len_a), 128'(0));
    check("rst_seq_err", 128'(err_a), 128'(0));
    check("rst_rd_slot", 128'(rd_slot_a), 128'(0));
    check("rst_timeout", 128'(to_a), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("bram_ce", 128'(ce_a), 128'(1));

    // Empty ring: head equals write pointer.
    en_a = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (tx_en_a) seen = 1'b1; end
    check("empty_ring_no_tx_en", 128'(seen), 128'(0));

    for (int i = 0; i < 7; i++) begin
      write_slot_a(make_hdr(tbl[i].last, tbl[i].rank, tbl[i].w, tbl[i].t, tbl[i].sign));
      serve_a();
      check("tbl_len", 128'(len_a), 128'(tbl[i].len));
      check("tbl_id", 128'(id_a), 128'(tbl[i].id));
      check("tbl_err", 128'(err_a), 128'(tbl[i].err));
      check("tbl_rank", 128'(rank_a), 128'(tbl[i].rank));
      check("tbl_last", 128'(last_a), 128'(tbl[i].last));
      if (i == 2) check("head_after_three", 128'(rd_slot_a), 128'(3));
    end

    // Randomized traffic; the first batch fills 15 slots and wraps the ring.
    ws = m_sign;
    for (int b = 0; b < 8; b++) begin
      k = (b == 0) ? 15 : $urandom_range(2, 6);
      for (int j = 0; j < k; j++) begin
        s = ws;
        if ($urandom_range(0, 7) == 0) s = ws + 32'($urandom_range(1, 1000));
        write_slot_a(make_hdr(1'($urandom), 15'($urandom), 8'($urandom), 8'($urandom), s));
        ws = s + 32'd1;
      end
      for (int j = 0; j < k; j++) serve_a();
    end

    // Transmitter never starts: slot abandoned after 20 SEND cycles.
    slot = m_head;
    write_slot_a(make_hdr(1'b0, 15'h0003, 8'd2, 8'd0, m_sign));
    hb = hdr_q.pop_front();
    m_sign = hb[31:0] + 32'd1;
    m_id = m_id + 16'd2;
    wait_tx_en_a("to_tx_en_rise");
    n = 0;
    while (tx_en_a === 1'b1 && n < 100) begin n++; @(negedge clk); end
    check("timeout_send_cycles", 128'(n), 128'(20));
    check("timeout_pulse_high", 128'(to_a), 128'(1));
    @(negedge clk);
    check("timeout_pulse_one_cycle", 128'(to_a), 128'(0));
    check("timeout_head_adv", 128'(rd_slot_a), 128'(slot + 4'd1));
    m_head = slot + 4'd1;

    // Reset during SEND.
    write_slot_a(make_hdr(1'b0, 15'h0004, 8'd3, 8'd1, m_sign));
    wait_tx_en_a("rst_tx_en_rise");
    rst_n = 1'b0;
    #1;
    check("midrst_tx_en", 128'(tx_en_a), 128'(0));
    check("midrst_ipv4_id", 128'(id_a), 128'(0));
    check("midrst_len", 128'(len_a), 128'(0));
    check("midrst_rank", 128'(rank_a), 128'(0));
    check("midrst_err", 128'(err_a), 128'(0));
    check("midrst_rd_slot", 128'(rd_slot_a), 128'(0));
    hdr_q.delete();
    m_sign = 0; m_id = 0; m_err = 0; m_head = 0;
    wr_a = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    write_slot_a(make_hdr(1'b0, 15'h0005, 8'd10, 8'd5, 32'd0));
    serve_a();

    // Drop mode: slot 1 carries sign 5 while 1 is expected.
    mem[11'h000] = make_hdr(1'b0, 15'h0100, 8'd10, 8'd5, 32'd0);
    mem[11'h080] = make_hdr(1'b0, 15'h0101, 8'd10, 8'd5, 32'd5);
    wr_b = 4'd2;
    en_b = 1'b1;
    n = 0;
    while (tx_en_b !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("drop_first_tx_en", 128'(tx_en_b), 128'(1));
    check("drop_first_id", 128'(id_b), 128'(2));
    check("drop_first_len", 128'(len_b), 128'(165));
    started_b = 1'b1;
    @(negedge clk);
    started_b = 1'b0;
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (tx_en_b) seen = 1'b1; end
    check("drop_no_tx_en", 128'(seen), 128'(0));
    check("drop_head_adv", 128'(rd_slot_b), 128'(2));
    check("drop_err_cnt", 128'(err_b), 128'(1));
    check("drop_id_held", 128'(id_b), 128'(2));
    mem[11'h100] = make_hdr(1'b1, 15'h0102, 8'd2, 8'd1, 32'd1);
    wr_b = 4'd3;
    n = 0;
    while (tx_en_b !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("drop_next_tx_en", 128'(tx_en_b), 128'(1));
    check("drop_next_id", 128'(id_b), 128'(4));
    check("drop_next_err", 128'(err_b), 128'(1));
    check("drop_next_len", 128'(len_b), 128'(17));
    check("drop_next_rank", 128'(rank_b), 128'(15'h0102));
    started_b = 1'b1;
    @(negedge clk);
    started_b = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
